// File: rtl/fifo_pack_pkg.sv
// rtl/fifo_pack_pkg.sv - shared state encoding and default geometry for the word packer
package fifo_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  localparam int FBITS_DEF  = 8;
  localparam int NLANES_DEF = 4;

endpackage

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs FIFO entries into NLANES-wide words, with flush of partial words
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int FBITS  = FBITS_DEF,
  parameter int NLANES = NLANES_DEF,
  localparam int LW    = $clog2(NLANES) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  input  logic [FBITS-1:0]        fifo_data,
  input  logic                    fifo_data_valid,
  input  logic                    flush,
  output logic [FBITS*NLANES-1:0] word_out,
  output logic [LW-1:0]           word_lanes,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    busy
);

  localparam logic [LW-1:0] LANES_MAX = LW'(NLANES);
  localparam logic [LW:0]   LANES_CMP = (LW + 1)'(NLANES);

  pack_state_e             state_q, state_d;
  logic [LW-1:0]           lane_cnt_q, lane_cnt_d;
  logic                    inflight_q, inflight_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [FBITS*NLANES-1:0] word_q, word_d;

  logic [LW:0] fill_sum;
  logic        rd_c;
  logic        data_take;

  // Reads in flight count against capacity so a full word never overflows.
  assign fill_sum  = {1'b0, lane_cnt_q} + {{LW{1'b0}}, inflight_q};
  assign rd_c      = !rst && (state_q == FILL) && !fifo_empty && !flush_pend_q
                     && (fill_sum < LANES_CMP);
  // Data is only accepted for a read this packer actually issued since reset.
  assign data_take = fifo_data_valid && inflight_q && (lane_cnt_q < LANES_MAX);

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    inflight_d   = inflight_q;
    flush_pend_d = flush_pend_q;
    word_d       = word_q;
    case (state_q)
      FILL: begin
        if (rd_c) begin
          inflight_d = 1'b1;
        end else if (fifo_data_valid) begin
          inflight_d = 1'b0;
        end
        if (data_take) begin
          for (int k = 0; k < NLANES; k++) begin
            if (lane_cnt_q == LW'(k)) begin
              word_d[k*FBITS +: FBITS] = fifo_data;
            end
          end
          lane_cnt_d = lane_cnt_q + 1'b1;
        end
        if (flush && ((lane_cnt_q != '0) || inflight_q)) begin
          flush_pend_d = 1'b1;
        end
        if ((lane_cnt_d == LANES_MAX) || (flush_pend_d && !inflight_d)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_d      = FILL;
          lane_cnt_d   = '0;
          flush_pend_d = 1'b0;
          word_d       = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      lane_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      word_q       <= word_d;
    end
  end

  assign fifo_rd    = rd_c;
  assign word_valid = (state_q == HOLD);
  assign word_out   = word_q;
  assign word_lanes = (state_q == HOLD) ? lane_cnt_q : '0;
  assign busy       = (lane_cnt_q != '0) || inflight_q || flush_pend_q;

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter FBITS, default 8, width of one FIFO entry.
REQ-002 Parameter NLANES, default 4, entries per output word; SHALL be a power of two, 2..8.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port fifo_empty  input  1  empty flag of the upstream FIFO.
REQ-006 Port fifo_rd  output  1  read strobe to the upstream FIFO.
REQ-007 Port fifo_data  input  FBITS  FIFO read data.
REQ-008 Port fifo_data_valid  input  1  FIFO read-data qualifier, one cycle after an accepted read.
REQ-009 Port flush  input  1  single-cycle request to emit the current partial word.
REQ-010 Port word_out  output  FBITS*NLANES  packed word; entry k occupies bits [k*FBITS +: FBITS].
REQ-011 Port word_lanes  output  clog2(NLANES)+1  count of valid lanes in word_out, 1..NLANES.
REQ-012 Port word_valid  output  1  word_out/word_lanes valid.
REQ-013 Port word_ready  input  1  downstream accepts the word when high together with word_valid.
REQ-014 Port busy  output  1  high whenever lane count, in-flight read, or pending flush is nonzero.

Function
REQ-015 States: FILL and HOLD; reset state FILL.
REQ-016 Internal: lane_cnt (0..NLANES), inflight (1 bit), flush_pend (1 bit), word register.
REQ-017 In FILL, fifo_rd = !fifo_empty && !flush_pend && (lane_cnt + inflight < NLANES); combinational.
REQ-018 inflight SHALL be set the cycle after fifo_rd is asserted and cleared when fifo_data_valid is sampled with no new read.
REQ-019 On fifo_data_valid, fifo_data SHALL be written into lane lane_cnt and lane_cnt SHALL increment by 1.
REQ-020 fifo_data_valid while lane_cnt == NLANES SHALL be impossible by REQ-017; the bench SHALL flag it as an error.
REQ-021 FILL->HOLD when lane_cnt reaches NLANES; word_lanes = NLANES.
REQ-022 flush with lane_cnt == 0 and inflight == 0 SHALL be ignored.
REQ-023 flush otherwise SHALL set flush_pend; no new reads issue; on inflight == 0, FILL->HOLD with word_lanes = lane_cnt.
REQ-024 flush arriving in HOLD SHALL be ignored.
REQ-025 In HOLD, word_valid = 1, fifo_rd = 0; word_out/word_lanes SHALL be stable until accepted.
REQ-026 On word_valid && word_ready: lane_cnt <= 0, flush_pend <= 0, unused lanes of the word cleared to 0, HOLD->FILL.
REQ-027 Unfilled lanes of a partial word SHALL read as zero.
REQ-028 Throughput: with FIFO never empty and word_ready high, one full word every NLANES+2 cycles.
REQ-029 Latency: first fifo_rd to word_valid = NLANES+1 cycles when the FIFO stays non-empty.

Reset
REQ-030 rst high SHALL immediately force: state FILL, lane_cnt 0, inflight 0, flush_pend 0, word register 0.
REQ-031 During and after reset: fifo_rd 0, word_valid 0, word_out 0, word_lanes 0, busy 0.
REQ-032 A read in flight at reset assertion SHALL be discarded; the fifo_data_valid pulse following reset release SHALL be ignored if inflight is 0.

Structure
REQ-033 Shared package fifo_pack_pkg SHALL hold the state enumeration (FILL, HOLD) and the default FBITS/NLANES constants.
REQ-034 No sub-module; lane write-enable decoder is inline logic.

Verification
REQ-035 FIFO preloaded 0x11,0x22,0x33,0x44, word_ready=1 -> word_valid one cycle, word_out=0x44332211, word_lanes=4.
REQ-036 FIFO holds 0xA1,0xB2; flush after both valid -> word_out=0x0000B2A1, word_lanes=2, no further fifo_rd until acceptance.
REQ-037 word_ready=0 for 10 cycles with full word held, FIFO non-empty -> fifo_rd stays 0, word_out constant 10 cycles.
REQ-038 flush asserted same cycle as fifo_rd of 3rd entry (0x01,0x02,0x03) -> waits for valid, emits 0x00030201, word_lanes=3.
REQ-039 rst pulsed one cycle after fifo_rd with 2 lanes filled -> all outputs 0, late fifo_data_valid ignored, next word starts at lane 0.
REQ-040 flush with empty packer and FIFO empty -> no word_valid, busy stays 0.
